// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one single-port picture ROM between the VGA
// scan-out (display, strict priority) and the feature scanner. A tag pipe
// of ROM_LAT stages follows every issued read so the returned word is
// steered to the reader that asked for it.
//
// Handshake: the display has no back-pressure; a read is taken in every
// cycle disp_req=1. The scanner holds scan_req and a stable scan_addr
// until scan_gnt=1 in the same cycle; that cycle is the transfer. Each
// reader sees exactly one *_vld pulse per accepted read, in issue order.
//
// Optional build macro ARB_STARVE_GUARD_EN: adds parameter STARVE_MAX and
// output disp_miss. Once the scanner has waited STARVE_MAX cycles it is
// granted over the display; the displaced display read is reported on
// disp_miss in the cycle its disp_vld would have appeared.
module rom_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1,   // legal 1..4
  parameter int WAIT_W  = 12
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_MAX = 1023
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_vld,
  output logic [DATA_W-1:0] disp_data,
`ifdef ARB_STARVE_GUARD_EN
  output logic              disp_miss,
`endif
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_gnt,
  output logic              scan_vld,
  output logic [DATA_W-1:0] scan_data,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    SCAN = 2'd2
  } owner_t;

  owner_t              state;
  owner_t              state_nxt;
  logic                grant_disp;
  logic                grant_scan;
  logic [WAIT_W-1:0]   wait_cnt;

  // Tag pipe: valid bit and owner bit (1 = scanner) per in-flight read.
  logic [ROM_LAT-1:0]  tag_v;
  logic [ROM_LAT-1:0]  tag_s;

  logic [DATA_W-1:0]   disp_hold;
  logic [DATA_W-1:0]   scan_hold;

`ifdef ARB_STARVE_GUARD_EN
  logic                force_scan;
  logic                miss_now;
  logic [ROM_LAT-1:0]  tag_m;

  assign force_scan = scan_req && (wait_cnt >= WAIT_W'(STARVE_MAX));
`endif

  // Arbitration and next owner: display first, scanner in unused cycles.
  always_comb begin
    grant_disp = 1'b0;
    grant_scan = 1'b0;
    state_nxt  = IDLE;
`ifdef ARB_STARVE_GUARD_EN
    miss_now   = 1'b0;
    if (force_scan) begin
      grant_scan = 1'b1;
      miss_now   = disp_req;
      state_nxt  = SCAN;
    end else
`endif
    if (disp_req) begin
      grant_disp = 1'b1;
      state_nxt  = DISP;
    end else if (scan_req) begin
      grant_scan = 1'b1;
      state_nxt  = SCAN;
    end
  end

  assign scan_gnt = grant_scan;
  assign rom_en   = disp_req | scan_req;
  assign rom_addr = grant_disp ? disp_addr : (scan_req ? scan_addr : '0);
  assign owner    = state;

  // Owner register: remembers which reader was granted last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Scanner wait counter: cycles spent requesting without a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                wait_cnt <= '0;
    else if (grant_scan)                       wait_cnt <= '0;
    else if (scan_req && (wait_cnt != '1))     wait_cnt <= wait_cnt + 1'b1;
  end

  // Tag pipe: stage 0 takes this cycle's grant, then shifts toward the ROM output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_s <= '0;
    end else begin
      tag_v[0] <= grant_disp | grant_scan;
      tag_s[0] <= grant_scan;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_s[i] <= tag_s[i-1];
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  // Miss tag: marks a display read displaced by a forced scanner grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_m <= '0;
    end else begin
      tag_m[0] <= miss_now;
      for (int i = 1; i < ROM_LAT; i++) tag_m[i] <= tag_m[i-1];
    end
  end

  assign disp_miss = tag_v[ROM_LAT-1] & tag_m[ROM_LAT-1];
`endif

  // The last tag stage lines up with the ROM word; vld comes straight from
  // the tag register and the word is passed through in that cycle.
  assign disp_vld  = tag_v[ROM_LAT-1] & ~tag_s[ROM_LAT-1];
  assign scan_vld  = tag_v[ROM_LAT-1] &  tag_s[ROM_LAT-1];
  assign disp_data = disp_vld ? rom_data : disp_hold;
  assign scan_data = scan_vld ? scan_data_sel() : scan_hold;

  function automatic logic [DATA_W-1:0] scan_data_sel();
    return rom_data;
  endfunction

  // Data hold registers: a reader's bus keeps its last word between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_hold <= '0;
      scan_hold <= '0;
    end else begin
      if (disp_vld) disp_hold <= rom_data;
      if (scan_vld) scan_hold <= rom_data;
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed bench for rom_port_arbiter. Two instances
// (ROM_LAT=2 and ROM_LAT=3) share the same request stimulus, each with its
// own ROM model; with ARB_STARVE_GUARD_EN a third instance (ROM_LAT=2,
// STARVE_MAX=8) covers the starvation guard.
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic        scan_req;
  logic [15:0] scan_addr;

  logic        disp_vld_w  [2];
  logic [7:0]  disp_data_w [2];
  logic        scan_gnt_w  [2];
  logic        scan_vld_w  [2];
  logic [7:0]  scan_data_w [2];
  logic        rom_en_w    [2];
  logic [15:0] rom_addr_w  [2];
  logic [7:0]  rom_data_w  [2];
  logic [1:0]  owner_w     [2];

  logic [7:0]  rp2 [2];
  logic [7:0]  rp3 [3];

  logic [7:0]  exp_q0 [$];
  logic [7:0]  exp_q1 [$];

  int compared = 0;
  int mismatched = 0;

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0] * 8'd37;
    return lo ^ a[15:8] ^ 8'h5A;
  endfunction

  // ROM models: registered read with 2 and 3 cycles of latency
  always @(posedge clk) begin
    rp2[0] <= rom_f(rom_addr_w[0]);
    rp2[1] <= rp2[0];
    rp3[0] <= rom_f(rom_addr_w[1]);
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign rom_data_w[0] = rp2[1];
  assign rom_data_w[1] = rp3[2];

  rom_port_arbiter #(.ADDR_W(16), .DATA_W(8), .ROM_LAT(2), .WAIT_W(12)) u_lat2 (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_vld(disp_vld_w[0]), .disp_data(disp_data_w[0]),
`ifdef ARB_STARVE_GUARD_EN
    .disp_miss(),
`endif
    .scan_req(scan_req), .scan_addr(scan_addr),
    .scan_gnt(scan_gnt_w[0]), .scan_vld(scan_vld_w[0]), .scan_data(scan_data_w[0]),
    .rom_en(rom_en_w[0]), .rom_addr(rom_addr_w[0]), .rom_data(rom_data_w[0]),
    .owner(owner_w[0])
  );

  rom_port_arbiter #(.ADDR_W(16), .DATA_W(8), .ROM_LAT(3), .WAIT_W(12)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_vld(disp_vld_w[1]), .disp_data(disp_data_w[1]),
`ifdef ARB_STARVE_GUARD_EN
    .disp_miss(),
`endif
    .scan_req(scan_req), .scan_addr(scan_addr),
    .scan_gnt(scan_gnt_w[1]), .scan_vld(scan_vld_w[1]), .scan_data(scan_data_w[1]),
    .rom_en(rom_en_w[1]), .rom_addr(rom_addr_w[1]), .rom_data(rom_data_w[1]),
    .owner(owner_w[1])
  );

`ifdef ARB_STARVE_GUARD_EN
  logic        g_disp_vld, g_disp_miss, g_scan_gnt, g_scan_vld, g_rom_en;
  logic [7:0]  g_disp_data, g_scan_data, g_rom_data;
  logic [15:0] g_rom_addr;
  logic [1:0]  g_owner;
  logic [7:0]  gp [2];

  always @(posedge clk) begin
    gp[0] <= rom_f(g_rom_addr);
    gp[1] <= gp[0];
  end
  assign g_rom_data = gp[1];

  rom_port_arbiter #(.ADDR_W(16), .DATA_W(8), .ROM_LAT(2), .WAIT_W(12), .STARVE_MAX(8)) u_grd (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_vld(g_disp_vld), .disp_data(g_disp_data), .disp_miss(g_disp_miss),
    .scan_req(scan_req), .scan_addr(scan_addr),
    .scan_gnt(g_scan_gnt), .scan_vld(g_scan_vld), .scan_data(g_scan_data),
    .rom_en(g_rom_en), .rom_addr(g_rom_addr), .rom_data(g_rom_data),
    .owner(g_owner)
  );
`endif

  // scanner protocol: address held while a request waits for its grant
  a_scan_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (scan_req && !scan_gnt_w[0]) |=> $stable(scan_addr));

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; disp_req = 1'b0; scan_req = 1'b0; disp_addr = '0; scan_addr = '0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      compared++; if (disp_vld_w[k] !== 1'b0) begin mismatched++; $display("FAIL rst_disp_vld k=%0d got %0b want 0", k, disp_vld_w[k]); end
      compared++; if (scan_vld_w[k] !== 1'b0) begin mismatched++; $display("FAIL rst_scan_vld k=%0d got %0b want 0", k, scan_vld_w[k]); end
      compared++; if (disp_data_w[k] !== 8'h00) begin mismatched++; $display("FAIL rst_disp_data k=%0d got %0h want 0", k, disp_data_w[k]); end
      compared++; if (scan_data_w[k] !== 8'h00) begin mismatched++; $display("FAIL rst_scan_data k=%0d got %0h want 0", k, scan_data_w[k]); end
      compared++; if (owner_w[k] !== 2'd0) begin mismatched++; $display("FAIL rst_owner k=%0d got %0d want 0", k, owner_w[k]); end
    end
    compared++; if (u_lat2.wait_cnt !== 12'd0) begin mismatched++; $display("FAIL rst_wait got %0d want 0", u_lat2.wait_cnt); end
    tick();
    rst_n = 1'b1;
    // cycle A: display read in flight
    disp_req = 1'b1; disp_addr = 16'h0010;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      compared++; if (rom_en_w[k] !== 1'b1) begin mismatched++; $display("FAIL rom_en k=%0d got %0b want 1", k, rom_en_w[k]); end
      compared++; if (rom_addr_w[k] !== 16'h0010) begin mismatched++; $display("FAIL rom_addr k=%0d got %0h want 0010", k, rom_addr_w[k]); end
    end
    tick();
    // cycle B: display again, scanner waits
    disp_addr = 16'h0011; scan_req = 1'b1; scan_addr = 16'h0020;
    @(negedge clk);
    compared++; if (scan_gnt_w[0] !== 1'b0) begin mismatched++; $display("FAIL conflict_gnt got %0b want 0", scan_gnt_w[0]); end
    tick();
    // cycles C, D: reset with reads in flight
    for (int c = 0; c < 2; c++) begin
      rst_n = 1'b0;
      if (c == 0) disp_addr = 16'h0012;
      else begin disp_req = 1'b0; scan_req = 1'b0; end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        compared++; if (disp_vld_w[k] !== 1'b0) begin mismatched++; $display("FAIL mid_rst_disp_vld k=%0d c=%0d got %0b want 0", k, c, disp_vld_w[k]); end
        compared++; if (scan_vld_w[k] !== 1'b0) begin mismatched++; $display("FAIL mid_rst_scan_vld k=%0d c=%0d got %0b want 0", k, c, scan_vld_w[k]); end
        compared++; if (disp_data_w[k] !== 8'h00) begin mismatched++; $display("FAIL mid_rst_disp_data k=%0d c=%0d got %0h want 0", k, c, disp_data_w[k]); end
        compared++; if (owner_w[k] !== 2'd0) begin mismatched++; $display("FAIL mid_rst_owner k=%0d c=%0d got %0d want 0", k, c, owner_w[k]); end
        if (c == 0) begin
          compared++; if (rom_addr_w[k] !== 16'h0012) begin mismatched++; $display("FAIL rst_rom_addr k=%0d got %0h want 0012", k, rom_addr_w[k]); end
        end
      end
      compared++; if (u_lat2.wait_cnt !== 12'd0) begin mismatched++; $display("FAIL mid_rst_wait c=%0d got %0d want 0", c, u_lat2.wait_cnt); end
      tick();
    end
    // cycles E, F: out of reset, nothing may come back
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        compared++; if (disp_vld_w[k] !== 1'b0 || scan_vld_w[k] !== 1'b0) begin mismatched++; $display("FAIL post_rst_vld k=%0d c=%0d got %0b%0b want 00", k, c, disp_vld_w[k], scan_vld_w[k]); end
        compared++; if (disp_data_w[k] !== 8'h00) begin mismatched++; $display("FAIL post_rst_data k=%0d c=%0d got %0h want 0", k, c, disp_data_w[k]); end
        compared++; if (owner_w[k] !== 2'd0) begin mismatched++; $display("FAIL post_rst_owner k=%0d c=%0d got %0d want 0", k, c, owner_w[k]); end
      end
      tick();
    end
  endtask

  task automatic test_display_only();
    for (int c = 0; c < 170; c++) begin
      disp_req = (c < 164); disp_addr = 16'(c); scan_req = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        automatic int lat = k + 2;
        automatic logic exp_v = (c >= lat) && (c < 164 + lat);
        automatic logic [1:0] exp_o = (c >= 1 && c <= 164) ? 2'd1 : 2'd0;
        compared++; if (disp_vld_w[k] !== exp_v) begin mismatched++; $display("FAIL disp_only_vld k=%0d c=%0d got %0b want %0b", k, c, disp_vld_w[k], exp_v); end
        compared++; if (scan_vld_w[k] !== 1'b0) begin mismatched++; $display("FAIL disp_only_scan_vld k=%0d c=%0d got %0b want 0", k, c, scan_vld_w[k]); end
        compared++; if (owner_w[k] !== exp_o) begin mismatched++; $display("FAIL disp_only_owner k=%0d c=%0d got %0d want %0d", k, c, owner_w[k], exp_o); end
        if (exp_v) begin
          compared++; if (disp_data_w[k] !== rom_f(16'(c - lat))) begin mismatched++; $display("FAIL disp_only_data k=%0d c=%0d got %0h want %0h", k, c, disp_data_w[k], rom_f(16'(c - lat))); end
        end else if (c >= 164 + lat) begin
          compared++; if (disp_data_w[k] !== rom_f(16'd163)) begin mismatched++; $display("FAIL disp_only_hold k=%0d c=%0d got %0h want %0h", k, c, disp_data_w[k], rom_f(16'd163)); end
        end
      end
      tick();
    end
  endtask

  task automatic test_conflict();
    for (int c = 0; c < 17; c++) begin
      disp_req = (c < 10); disp_addr = 16'h0100 + 16'(c);
      scan_req = (c <= 10); scan_addr = 16'h0ABC;
      @(negedge clk);
      compared++; if (scan_gnt_w[0] !== (c == 10)) begin mismatched++; $display("FAIL conflict_gnt c=%0d got %0b want %0b", c, scan_gnt_w[0], c == 10); end
      if (c <= 11) begin
        automatic logic [11:0] exp_w = (c <= 10) ? 12'(c) : 12'd0;
        compared++; if (u_lat2.wait_cnt !== exp_w) begin mismatched++; $display("FAIL conflict_wait c=%0d got %0d want %0d", c, u_lat2.wait_cnt, exp_w); end
      end
      if (c == 10) begin
        compared++; if (rom_addr_w[0] !== 16'h0ABC) begin mismatched++; $display("FAIL conflict_rom_addr got %0h want 0abc", rom_addr_w[0]); end
      end
      for (int k = 0; k < 2; k++) begin
        automatic int lat = k + 2;
        automatic logic exp_dv = (c >= lat) && (c < 10 + lat);
        automatic logic exp_sv = (c == 10 + lat);
        compared++; if (disp_vld_w[k] !== exp_dv) begin mismatched++; $display("FAIL conflict_disp_vld k=%0d c=%0d got %0b want %0b", k, c, disp_vld_w[k], exp_dv); end
        compared++; if (scan_vld_w[k] !== exp_sv) begin mismatched++; $display("FAIL conflict_scan_vld k=%0d c=%0d got %0b want %0b", k, c, scan_vld_w[k], exp_sv); end
        if (exp_dv) begin
          compared++; if (disp_data_w[k] !== rom_f(16'h0100 + 16'(c - lat))) begin mismatched++; $display("FAIL conflict_disp_data k=%0d c=%0d got %0h want %0h", k, c, disp_data_w[k], rom_f(16'h0100 + 16'(c - lat))); end
        end
        if (c >= 10 + lat) begin
          compared++; if (scan_data_w[k] !== rom_f(16'h0ABC)) begin mismatched++; $display("FAIL conflict_scan_data k=%0d c=%0d got %0h want %0h", k, c, scan_data_w[k], rom_f(16'h0ABC)); end
        end
        if (c == 10 || c == 11) begin
          automatic logic [1:0] exp_o = (c == 10) ? 2'd1 : 2'd2;
          compared++; if (owner_w[k] !== exp_o) begin mismatched++; $display("FAIL conflict_owner k=%0d c=%0d got %0d want %0d", k, c, owner_w[k], exp_o); end
        end
      end
      tick();
    end
  endtask

  task automatic test_alternation();
    for (int c = 0; c < 13; c++) begin
      disp_req = (c < 8) && (c % 2 == 0); disp_addr = 16'h0200 + 16'(c);
      scan_req = (c < 8) && (c % 2 == 1); scan_addr = 16'h0300 + 16'(c);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        automatic int lat = k + 2;
        automatic int s = c - lat;
        automatic logic exp_dv = (s >= 0) && (s < 8) && (s % 2 == 0);
        automatic logic exp_sv = (s >= 0) && (s < 8) && (s % 2 == 1);
        automatic logic [1:0] exp_o = (c >= 1 && c <= 8) ? (((c - 1) % 2 == 0) ? 2'd1 : 2'd2) : 2'd0;
        compared++; if (disp_vld_w[k] !== exp_dv) begin mismatched++; $display("FAIL alt_disp_vld k=%0d c=%0d got %0b want %0b", k, c, disp_vld_w[k], exp_dv); end
        compared++; if (scan_vld_w[k] !== exp_sv) begin mismatched++; $display("FAIL alt_scan_vld k=%0d c=%0d got %0b want %0b", k, c, scan_vld_w[k], exp_sv); end
        compared++; if (owner_w[k] !== exp_o) begin mismatched++; $display("FAIL alt_owner k=%0d c=%0d got %0d want %0d", k, c, owner_w[k], exp_o); end
        if (exp_dv) begin
          compared++; if (disp_data_w[k] !== rom_f(16'h0200 + 16'(s))) begin mismatched++; $display("FAIL alt_disp_data k=%0d c=%0d got %0h want %0h", k, c, disp_data_w[k], rom_f(16'h0200 + 16'(s))); end
          if (s >= 2) begin
            compared++; if (scan_data_w[k] !== rom_f(16'h0300 + 16'(s - 1))) begin mismatched++; $display("FAIL alt_scan_hold k=%0d c=%0d got %0h want %0h", k, c, scan_data_w[k], rom_f(16'h0300 + 16'(s - 1))); end
          end
        end
        if (exp_sv) begin
          compared++; if (scan_data_w[k] !== rom_f(16'h0300 + 16'(s))) begin mismatched++; $display("FAIL alt_scan_data k=%0d c=%0d got %0h want %0h", k, c, scan_data_w[k], rom_f(16'h0300 + 16'(s))); end
          compared++; if (disp_data_w[k] !== rom_f(16'h0200 + 16'(s - 1))) begin mismatched++; $display("FAIL alt_disp_hold k=%0d c=%0d got %0h want %0h", k, c, disp_data_w[k], rom_f(16'h0200 + 16'(s - 1))); end
        end
      end
      tick();
    end
  endtask

  task automatic test_blanking();
    automatic logic [15:0] scan_a = 16'h1000;
    automatic int gcnt [2] = '{0, 0};
    automatic int dcnt [2] = '{0, 0};
    exp_q0.delete(); exp_q1.delete();
    for (int c = 0; c < 1606; c++) begin
      automatic int line = c / 800;
      automatic int pos = c % 800;
      disp_req = (c < 1600) && (pos < 640); disp_addr = 16'(c);
      scan_req = (c < 1600); scan_addr = scan_a;
      @(negedge clk);
      if (c < 1600 && pos == 640) begin
        compared++; if (u_lat2.wait_cnt !== 12'd640) begin mismatched++; $display("FAIL blank_wait line=%0d got %0d want 640", line, u_lat2.wait_cnt); end
      end
      for (int k = 0; k < 2; k++) begin
        if (disp_vld_w[k] === 1'b1) dcnt[k]++;
        if (scan_vld_w[k] === 1'b1) begin
          automatic logic [7:0] e;
          compared++;
          if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            mismatched++; $display("FAIL blank_scan_extra k=%0d c=%0d got %0h want none", k, c, scan_data_w[k]);
          end else begin
            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (scan_data_w[k] !== e) begin mismatched++; $display("FAIL blank_scan_data k=%0d c=%0d got %0h want %0h", k, c, scan_data_w[k], e); end
          end
        end
      end
      if (scan_gnt_w[0] === 1'b1) begin
        if (line < 2) gcnt[line]++;
        exp_q0.push_back(rom_f(scan_a));
        exp_q1.push_back(rom_f(scan_a));
        scan_a = scan_a + 16'd1;
      end
      tick();
    end
    for (int l = 0; l < 2; l++) begin
      compared++; if (gcnt[l] != 160) begin mismatched++; $display("FAIL blank_gnt_count line=%0d got %0d want 160", l, gcnt[l]); end
    end
    for (int k = 0; k < 2; k++) begin
      compared++; if (dcnt[k] != 1280) begin mismatched++; $display("FAIL blank_disp_count k=%0d got %0d want 1280", k, dcnt[k]); end
    end
    compared++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin mismatched++; $display("FAIL blank_scan_left got %0d/%0d want 0/0", exp_q0.size(), exp_q1.size()); end
  endtask

`ifdef ARB_STARVE_GUARD_EN
  task automatic test_starve_guard();
    automatic int misses = 0;
    for (int c = 0; c < 16; c++) begin
      disp_req = (c < 12); disp_addr = 16'h0400 + 16'(c);
      scan_req = (c <= 8); scan_addr = 16'h0777;
      @(negedge clk);
      begin
        automatic int s = c - 2;
        automatic logic exp_dv = (s >= 0) && (s < 12) && (s != 8);
        automatic logic exp_ev = (s == 8);
        if (c <= 8) begin
          compared++; if (u_grd.wait_cnt !== 12'(c)) begin mismatched++; $display("FAIL guard_wait c=%0d got %0d want %0d", c, u_grd.wait_cnt, c); end
        end
        compared++; if (g_scan_gnt !== (c == 8)) begin mismatched++; $display("FAIL guard_gnt c=%0d got %0b want %0b", c, g_scan_gnt, c == 8); end
        if (c == 8) begin
          compared++; if (g_rom_addr !== 16'h0777) begin mismatched++; $display("FAIL guard_rom_addr got %0h want 0777", g_rom_addr); end
        end
        compared++; if (g_disp_vld !== exp_dv) begin mismatched++; $display("FAIL guard_disp_vld c=%0d got %0b want %0b", c, g_disp_vld, exp_dv); end
        compared++; if (g_disp_miss !== exp_ev) begin mismatched++; $display("FAIL guard_miss c=%0d got %0b want %0b", c, g_disp_miss, exp_ev); end
        compared++; if (g_scan_vld !== exp_ev) begin mismatched++; $display("FAIL guard_scan_vld c=%0d got %0b want %0b", c, g_scan_vld, exp_ev); end
        if (exp_dv) begin
          compared++; if (g_disp_data !== rom_f(16'h0400 + 16'(s))) begin mismatched++; $display("FAIL guard_disp_data c=%0d got %0h want %0h", c, g_disp_data, rom_f(16'h0400 + 16'(s))); end
        end
        if (exp_ev) begin
          compared++; if (g_scan_data !== rom_f(16'h0777)) begin mismatched++; $display("FAIL guard_scan_data got %0h want %0h", g_scan_data, rom_f(16'h0777)); end
        end
        if (g_disp_miss === 1'b1) misses++;
      end
      tick();
    end
    compared++; if (misses != 1) begin mismatched++; $display("FAIL guard_miss_count got %0d want 1", misses); end
  endtask
`endif

  initial begin
    test_reset();
    test_display_only();
    test_conflict();
    test_alternation();
    test_blanking();
`ifdef ARB_STARVE_GUARD_EN
    test_starve_guard();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
